// File: rtl/mat_operand_sequencer.sv
// Operand sequencer for the 4-lane dot-product stage: stores 4x4 A and B matrices
// and streams all 16 (row of A, column of B) operand sets, with result-aligned tags.
module mat_operand_sequencer #(
  parameter int WIDTH_A_80 = 9,
  parameter int WIDTH_B_80 = 8,
  parameter int PIPE_LAT   = 1
) (
  input  logic                  clk_80,
  input  logic                  rst_80,
  input  logic                  wr_en_80,
  input  logic                  wr_sel_80,
  input  logic [3:0]            wr_addr_80,
  input  logic [WIDTH_A_80-1:0] wr_data_80,
  input  logic                  start_80,
  output logic                  busy_80,
  output logic [WIDTH_A_80-1:0] A00_80,
  output logic [WIDTH_A_80-1:0] A01_80,
  output logic [WIDTH_A_80-1:0] A02_80,
  output logic [WIDTH_A_80-1:0] A03_80,
  output logic [WIDTH_B_80-1:0] B00_80,
  output logic [WIDTH_B_80-1:0] B01_80,
  output logic [WIDTH_B_80-1:0] B02_80,
  output logic [WIDTH_B_80-1:0] B03_80,
  output logic                  op_valid_80,
  output logic                  res_valid_80,
  output logic [1:0]            res_row_80,
  output logic [1:0]            res_col_80,
  output logic                  done_80
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CW = $clog2(PIPE_LAT + 1);

  state_t                  state;
  logic [WIDTH_A_80-1:0]   mem_a [16];
  logic [WIDTH_B_80-1:0]   mem_b [16];
  logic [WIDTH_A_80-1:0]   a_op  [4];
  logic [WIDTH_B_80-1:0]   b_op  [4];
  logic [1:0]              row;
  logic [1:0]              col;
  logic [CW-1:0]           drain_cnt;
  logic [3:0]              nxt_idx;
  logic [1:0]              nxt_row;
  logic [1:0]              nxt_col;
  logic                    wr_ok;
  logic                    launch;
  logic                    dv [PIPE_LAT];
  logic [1:0]              dr [PIPE_LAT];
  logic [1:0]              dc [PIPE_LAT];

  // Handshake: start_80 is taken only while busy_80=0 and no write is requested;
  // busy_80 then stays high through RUN and DRAIN, and drops in the done_80 cycle.
  assign wr_ok   = wr_en_80 && (state == IDLE);
  assign launch  = start_80 && !wr_en_80 && (state == IDLE);
  assign nxt_idx = (state == IDLE) ? 4'd0 : ({row, col} + 4'd1);
  assign nxt_row = nxt_idx[3:2];
  assign nxt_col = nxt_idx[1:0];

  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      for (int e = 0; e < 16; e++) begin
        mem_a[e] <= '0;
        mem_b[e] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel_80) mem_b[wr_addr_80] <= wr_data_80[WIDTH_B_80-1:0];
      else           mem_a[wr_addr_80] <= wr_data_80;
    end
  end

  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      state       <= IDLE;
      row         <= 2'd0;
      col         <= 2'd0;
      drain_cnt   <= '0;
      busy_80     <= 1'b0;
      op_valid_80 <= 1'b0;
      done_80     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        a_op[k] <= '0;
        b_op[k] <= '0;
      end
    end else begin
      done_80 <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state       <= RUN;
            busy_80     <= 1'b1;
            op_valid_80 <= 1'b1;
            row         <= 2'd0;
            col         <= 2'd0;
            for (int k = 0; k < 4; k++) begin
              a_op[k] <= mem_a[{nxt_row, 2'(k)}];
              b_op[k] <= mem_b[{2'(k), nxt_col}];
            end
          end
        end
        RUN: begin
          if ({row, col} == 4'hF) begin
            state       <= DRAIN;
            op_valid_80 <= 1'b0;
            drain_cnt   <= '0;
            for (int k = 0; k < 4; k++) begin
              a_op[k] <= '0;
              b_op[k] <= '0;
            end
          end else begin
            row <= nxt_row;
            col <= nxt_col;
            for (int k = 0; k < 4; k++) begin
              a_op[k] <= mem_a[{nxt_row, 2'(k)}];
              b_op[k] <= mem_b[{2'(k), nxt_col}];
            end
          end
        end
        DRAIN: begin
          // Hold off done_80 until the last result has left the downstream register.
          if (drain_cnt == CW'(PIPE_LAT - 1)) begin
            state   <= IDLE;
            busy_80 <= 1'b0;
            done_80 <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags ride alongside op_valid_80 and are forced to zero outside valid cycles.
  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      for (int s = 0; s < PIPE_LAT; s++) begin
        dv[s] <= 1'b0;
        dr[s] <= 2'd0;
        dc[s] <= 2'd0;
      end
    end else begin
      dv[0] <= op_valid_80;
      dr[0] <= op_valid_80 ? row : 2'd0;
      dc[0] <= op_valid_80 ? col : 2'd0;
      for (int s = 1; s < PIPE_LAT; s++) begin
        dv[s] <= dv[s-1];
        dr[s] <= dr[s-1];
        dc[s] <= dc[s-1];
      end
    end
  end

  assign res_valid_80 = dv[PIPE_LAT-1];
  assign res_row_80   = dr[PIPE_LAT-1];
  assign res_col_80   = dc[PIPE_LAT-1];

  assign A00_80 = a_op[0];
  assign A01_80 = a_op[1];
  assign A02_80 = a_op[2];
  assign A03_80 = a_op[3];
  assign B00_80 = b_op[0];
  assign B01_80 = b_op[1];
  assign B02_80 = b_op[2];
  assign B03_80 = b_op[3];

endmodule

// File: tb/tb_mat_operand_sequencer.sv
// Bench for mat_operand_sequencer: a matrix/stream reference model checked per scenario.
module tb_mat_operand_sequencer;

  localparam int WA  = 9;
  localparam int WB  = 8;
  localparam int L   = 1;
  localparam int CAP = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          wr_sel;
  logic [3:0]    wr_addr;
  logic [WA-1:0] wr_data;
  logic          start;
  logic          busy;
  logic [WA-1:0] a00, a01, a02, a03;
  logic [WB-1:0] b00, b01, b02, b03;
  logic          op_valid;
  logic          res_valid;
  logic [1:0]    res_row;
  logic [1:0]    res_col;
  logic          done;

  int checks   = 0;
  int failures = 0;

  // Reference model: stored matrices, indexed row*4+col.
  logic [WA-1:0] ref_a [16];
  logic [WB-1:0] ref_b [16];

  // Per-cycle capture; index c = c-th cycle after the start was sampled.
  logic          cap_ov   [CAP];
  logic [WA-1:0] cap_a    [CAP][4];
  logic [WB-1:0] cap_b    [CAP][4];
  logic          cap_rv   [CAP];
  logic [1:0]    cap_rr   [CAP];
  logic [1:0]    cap_rc   [CAP];
  logic          cap_done [CAP];
  logic          cap_busy [CAP];

  mat_operand_sequencer #(
    .WIDTH_A_80(WA),
    .WIDTH_B_80(WB),
    .PIPE_LAT  (L)
  ) dut (
    .clk_80      (clk),
    .rst_80      (rst),
    .wr_en_80    (wr_en),
    .wr_sel_80   (wr_sel),
    .wr_addr_80  (wr_addr),
    .wr_data_80  (wr_data),
    .start_80    (start),
    .busy_80     (busy),
    .A00_80      (a00),
    .A01_80      (a01),
    .A02_80      (a02),
    .A03_80      (a03),
    .B00_80      (b00),
    .B01_80      (b01),
    .B02_80      (b02),
    .B03_80      (b03),
    .op_valid_80 (op_valid),
    .res_valid_80(res_valid),
    .res_row_80  (res_row),
    .res_col_80  (res_col),
    .done_80     (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic exp_ov(input int c);
    return (c >= 1) && (c <= 16);
  endfunction

  function automatic logic [WA-1:0] exp_a(input int c, input int k);
    if (!exp_ov(c)) return '0;
    return ref_a[((c - 1) / 4) * 4 + k];
  endfunction

  function automatic logic [WB-1:0] exp_b(input int c, input int k);
    if (!exp_ov(c)) return '0;
    return ref_b[k * 4 + ((c - 1) % 4)];
  endfunction

  function automatic logic exp_rv(input int c);
    return (c - L >= 1) && (c - L <= 16);
  endfunction

  function automatic logic [3:0] exp_tag(input int c);
    logic [1:0] r;
    logic [1:0] q;
    if (!exp_rv(c)) return 4'd0;
    r = 2'((c - L - 1) / 4);
    q = 2'((c - L - 1) % 4);
    return {r, q};
  endfunction

  function automatic logic exp_done(input int c);
    return c == 17 + L;
  endfunction

  function automatic logic exp_busy(input int c);
    return (c >= 1) && (c <= 16 + L);
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 16; e++) begin
      ref_a[e] = '0;
      ref_b[e] = '0;
    end
  endtask

  task automatic write_entry(input logic sel, input logic [3:0] addr, input logic [WA-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) ref_b[addr] = data[WB-1:0];
    else     ref_a[addr] = data;
  endtask

  // Pulses start now, records n cycles; at cycle ev_c optionally drives start/A-write/reset.
  task automatic run_capture(input int n, input int ev_c, input logic ev_start, input logic ev_wr,
                             input logic [3:0] ev_addr, input logic [WA-1:0] ev_data, input logic ev_rst);
    for (int c = 0; c < CAP; c++) begin
      cap_ov[c] = 1'b0; cap_rv[c] = 1'b0; cap_rr[c] = 2'd0; cap_rc[c] = 2'd0;
      cap_done[c] = 1'b0; cap_busy[c] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        cap_a[c][k] = '0;
        cap_b[c][k] = '0;
      end
    end
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cap_ov[c] = op_valid;
      cap_a[c][0] = a00; cap_a[c][1] = a01; cap_a[c][2] = a02; cap_a[c][3] = a03;
      cap_b[c][0] = b00; cap_b[c][1] = b01; cap_b[c][2] = b02; cap_b[c][3] = b03;
      cap_rv[c] = res_valid; cap_rr[c] = res_row; cap_rc[c] = res_col;
      cap_done[c] = done; cap_busy[c] = busy;
      start = 1'b0; wr_en = 1'b0; rst = 1'b0;
      if (c == ev_c) begin
        start = ev_start; wr_en = ev_wr; wr_sel = 1'b0;
        wr_addr = ev_addr; wr_data = ev_data; rst = ev_rst;
      end
    end
    start = 1'b0; wr_en = 1'b0; rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd3; wr_data = WA'($urandom_range(1, 511));
    start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; start = 1'b0;
    for (int e = 0; e < 16; e++) begin
      ref_a[e] = '0;
      ref_b[e] = '0;
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if ({op_valid, res_valid, done} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000", {op_valid, res_valid, done});
    end
    checks++;
    if ({res_row, res_col} !== 4'd0) begin failures++; $display("FAIL reset_tags got=%h exp=0", {res_row, res_col}); end
    checks++;
    if ({a00, a01, a02, a03, b00, b01, b02, b03} !== '0) begin
      failures++; $display("FAIL reset_operands got=%h exp=0", {a00, a01, a02, a03, b00, b01, b02, b03});
    end
  endtask

  task automatic test_zero_sequence();
    int nv;
    nv = 0;
    run_capture(22, 0, 1'b0, 1'b0, 4'd0, '0, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      if (cap_ov[c]) nv++;
      checks++;
      if (cap_ov[c] !== exp_ov(c)) begin
        failures++; $display("FAIL zero_op_valid c=%0d got=%b exp=%b", c, cap_ov[c], exp_ov(c));
      end
      checks++;
      if ({cap_a[c][0], cap_a[c][1], cap_a[c][2], cap_a[c][3], cap_b[c][0], cap_b[c][1], cap_b[c][2], cap_b[c][3]} !== '0) begin
        failures++; $display("FAIL zero_operands c=%0d got=%h exp=0", c, {cap_a[c][0], cap_b[c][0]});
      end
    end
    checks++;
    if (nv != 16) begin failures++; $display("FAIL zero_valid_count got=%0d exp=16", nv); end
  endtask

  task automatic test_directed_load();
    logic [WA-1:0] ea7  [4];
    logic [WB-1:0] eb7  [4];
    logic [WA-1:0] ea16 [4];
    logic [WB-1:0] eb16 [4];
    ea7  = '{9'd5, 9'd6, 9'd7, 9'd8};
    eb7  = '{8'h02, 8'h12, 8'h22, 8'h32};
    ea16 = '{9'd13, 9'd14, 9'd15, 9'd16};
    eb16 = '{8'h03, 8'h13, 8'h23, 8'h33};
    for (int r = 0; r < 4; r++) begin
      for (int q = 0; q < 4; q++) begin
        write_entry(1'b0, 4'(r * 4 + q), WA'(r * 4 + q + 1));
        write_entry(1'b1, 4'(r * 4 + q), WA'(16 * r + q));
      end
    end
    run_capture(22, 0, 1'b0, 1'b0, 4'd0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap_a[7][k] !== ea7[k]) begin failures++; $display("FAIL dir_a_c7 k=%0d got=%h exp=%h", k, cap_a[7][k], ea7[k]); end
      checks++;
      if (cap_b[7][k] !== eb7[k]) begin failures++; $display("FAIL dir_b_c7 k=%0d got=%h exp=%h", k, cap_b[7][k], eb7[k]); end
      checks++;
      if (cap_a[16][k] !== ea16[k]) begin failures++; $display("FAIL dir_a_c16 k=%0d got=%h exp=%h", k, cap_a[16][k], ea16[k]); end
      checks++;
      if (cap_b[16][k] !== eb16[k]) begin failures++; $display("FAIL dir_b_c16 k=%0d got=%h exp=%h", k, cap_b[16][k], eb16[k]); end
    end
  endtask

  task automatic test_result_tagging();
    run_capture(22, 0, 1'b0, 1'b0, 4'd0, '0, 1'b0);
    checks++;
    if ({cap_rv[1], cap_rv[2], cap_rr[2], cap_rc[2]} !== 6'b01_0000) begin
      failures++; $display("FAIL tag_first got=%b exp=010000", {cap_rv[1], cap_rv[2], cap_rr[2], cap_rc[2]});
    end
    checks++;
    if ({cap_rv[17], cap_rr[17], cap_rc[17], cap_rv[18]} !== 6'b1_1111_0) begin
      failures++; $display("FAIL tag_last got=%b exp=111110", {cap_rv[17], cap_rr[17], cap_rc[17], cap_rv[18]});
    end
    for (int c = 1; c <= 22; c++) begin
      checks++;
      if ({cap_rv[c], cap_rr[c], cap_rc[c]} !== {exp_rv(c), exp_tag(c)}) begin
        failures++; $display("FAIL tag_stream c=%0d got=%b exp=%b", c, {cap_rv[c], cap_rr[c], cap_rc[c]}, {exp_rv(c), exp_tag(c)});
      end
      checks++;
      if ({cap_done[c], cap_busy[c]} !== {exp_done(c), exp_busy(c)}) begin
        failures++; $display("FAIL done_busy c=%0d got=%b exp=%b", c, {cap_done[c], cap_busy[c]}, {exp_done(c), exp_busy(c)});
      end
    end
  endtask

  task automatic test_write_during_run();
    run_capture(22, 3, 1'b1, 1'b1, 4'd0, 9'h0FF, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      checks++;
      if (cap_ov[c] !== exp_ov(c)) begin
        failures++; $display("FAIL wrrun_op_valid c=%0d got=%b exp=%b", c, cap_ov[c], exp_ov(c));
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cap_a[c][k] !== exp_a(c, k)) begin
          failures++; $display("FAIL wrrun_a c=%0d k=%0d got=%h exp=%h", c, k, cap_a[c][k], exp_a(c, k));
        end
      end
      checks++;
      if (cap_done[c] !== exp_done(c)) begin
        failures++; $display("FAIL wrrun_done c=%0d got=%b exp=%b", c, cap_done[c], exp_done(c));
      end
    end
    run_capture(22, 0, 1'b0, 1'b0, 4'd0, '0, 1'b0);
    checks++;
    if (cap_a[1][0] !== 9'd1) begin failures++; $display("FAIL wrrun_kept got=%h exp=001", cap_a[1][0]); end
  endtask

  task automatic test_write_with_start();
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 9'h100; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    ref_a[0] = 9'h100;
    checks++;
    if ({busy, op_valid} !== 2'b00) begin failures++; $display("FAIL wrstart_idle got=%b exp=00", {busy, op_valid}); end
    @(negedge clk);
    checks++;
    if ({busy, op_valid} !== 2'b00) begin failures++; $display("FAIL wrstart_idle2 got=%b exp=00", {busy, op_valid}); end
    run_capture(22, 0, 1'b0, 1'b0, 4'd0, '0, 1'b0);
    checks++;
    if ({cap_ov[1], cap_a[1][0]} !== {1'b1, 9'h100}) begin
      failures++; $display("FAIL wrstart_a00 got=%h exp=%h", {cap_ov[1], cap_a[1][0]}, {1'b1, 9'h100});
    end
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = 0;
    run_capture(36, 17 + L, 1'b1, 1'b0, 4'd0, '0, 1'b0);
    checks++;
    if ({cap_done[18], cap_busy[18]} !== 2'b10) begin
      failures++; $display("FAIL b2b_done_cycle got=%b exp=10", {cap_done[18], cap_busy[18]});
    end
    checks++;
    if ({cap_ov[19], cap_busy[19], cap_a[19][0]} !== {2'b11, exp_a(1, 0)}) begin
      failures++; $display("FAIL b2b_restart got=%h exp=%h", {cap_ov[19], cap_busy[19], cap_a[19][0]}, {2'b11, exp_a(1, 0)});
    end
    for (int c = 19; c <= 36; c++) if (cap_ov[c]) nv++;
    checks++;
    if (nv != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", nv); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({cap_a[34][k], cap_b[34][k]} !== {exp_a(16, k), exp_b(16, k)}) begin
        failures++; $display("FAIL b2b_last k=%0d got=%h exp=%h", k, {cap_a[34][k], cap_b[34][k]}, {exp_a(16, k), exp_b(16, k)});
      end
    end
    checks++;
    if (cap_done[36] !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", cap_done[36]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random_sequences();
    for (int it = 0; it < 3; it++) begin
      for (int e = 0; e < 16; e++) begin
        write_entry(1'b0, 4'(e), WA'($urandom_range(0, 511)));
        write_entry(1'b1, 4'(e), WA'($urandom_range(0, 511)));
      end
      run_capture(22, 0, 1'b0, 1'b0, 4'd0, '0, 1'b0);
      for (int c = 1; c <= 22; c++) begin
        checks++;
        if (cap_ov[c] !== exp_ov(c)) begin
          failures++; $display("FAIL rnd_op_valid it=%0d c=%0d got=%b exp=%b", it, c, cap_ov[c], exp_ov(c));
        end
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (cap_a[c][k] !== exp_a(c, k)) begin
            failures++; $display("FAIL rnd_a it=%0d c=%0d k=%0d got=%h exp=%h", it, c, k, cap_a[c][k], exp_a(c, k));
          end
          checks++;
          if (cap_b[c][k] !== exp_b(c, k)) begin
            failures++; $display("FAIL rnd_b it=%0d c=%0d k=%0d got=%h exp=%h", it, c, k, cap_b[c][k], exp_b(c, k));
          end
        end
        checks++;
        if ({cap_rv[c], cap_rr[c], cap_rc[c], cap_done[c], cap_busy[c]} !== {exp_rv(c), exp_tag(c), exp_done(c), exp_busy(c)}) begin
          failures++; $display("FAIL rnd_ctrl it=%0d c=%0d got=%b exp=%b", it, c,
                               {cap_rv[c], cap_rr[c], cap_rc[c], cap_done[c], cap_busy[c]},
                               {exp_rv(c), exp_tag(c), exp_done(c), exp_busy(c)});
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int nv;
    nv = 0;
    run_capture(22, 5, 1'b0, 1'b0, 4'd0, '0, 1'b1);
    for (int e = 0; e < 16; e++) begin
      ref_a[e] = '0;
      ref_b[e] = '0;
    end
    checks++;
    if (cap_ov[5] !== 1'b1) begin failures++; $display("FAIL midrst_c5_valid got=%b exp=1", cap_ov[5]); end
    checks++;
    if ({cap_ov[6], cap_busy[6], cap_rv[6], cap_rr[6], cap_rc[6], cap_done[6], cap_a[6][0], cap_b[6][3]} !== '0) begin
      failures++; $display("FAIL midrst_c6 got=%h exp=0",
                           {cap_ov[6], cap_busy[6], cap_rv[6], cap_rr[6], cap_rc[6], cap_done[6], cap_a[6][0], cap_b[6][3]});
    end
    for (int c = 6; c <= 22; c++) begin
      checks++;
      if ({cap_done[c], cap_ov[c], cap_busy[c]} !== 3'b000) begin
        failures++; $display("FAIL midrst_quiet c=%0d got=%b exp=000", c, {cap_done[c], cap_ov[c], cap_busy[c]});
      end
    end
    run_capture(22, 0, 1'b0, 1'b0, 4'd0, '0, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      if (cap_ov[c]) nv++;
      checks++;
      if ({cap_a[c][0], cap_a[c][1], cap_a[c][2], cap_a[c][3], cap_b[c][0], cap_b[c][1], cap_b[c][2], cap_b[c][3]} !== '0) begin
        failures++; $display("FAIL midrst_cleared c=%0d got=%h exp=0", c, {cap_a[c][0], cap_b[c][0]});
      end
    end
    checks++;
    if (nv != 16) begin failures++; $display("FAIL midrst_count got=%0d exp=16", nv); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = '0; start = 1'b0;
    test_reset();
    test_zero_sequence();
    test_directed_load();
    test_result_tagging();
    test_write_during_run();
    test_write_with_start();
    test_back_to_back();
    test_random_sequences();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mat_operand_sequencer.md
Name: mat_operand_sequencer

Overview:
Upstream operand feeder for the 4-lane row/column dot-product stage (mat_mult).
- Holds a 4x4 A matrix (WIDTH_A_80-bit entries) and a 4x4 B matrix (WIDTH_B_80-bit entries), loaded through a write port.
- On start, presents all 16 (row i of A, column j of B) operand sets, one per cycle, on the dot-product stage's A00..A03/B00..B03 inputs.
- Emits a result-valid strobe and (row, col) tag aligned to the downstream registered AB00_80 output, so a collector can assemble the 4x4 product.

Parameters:
- WIDTH_A_80, 9, A entry width (two's-complement fraction).
- WIDTH_B_80, 8, B entry width.
- PIPE_LAT, 1, cycles from operands presented to the registered result on AB00_80; must be >= 1.

Ports:
- clk_80 in 1: clock, all logic on rising edge.
- rst_80 in 1: synchronous, active-high reset.
- wr_en_80 in 1: matrix write strobe.
- wr_sel_80 in 1: write target, 0=A, 1=B.
- wr_addr_80 in 4: entry index, row*4+col.
- wr_data_80 in WIDTH_A_80: write data; B uses bits [WIDTH_B_80-1:0].
- start_80 in 1: begin a sequence.
- busy_80 out 1: sequence in progress.
- A00_80..A03_80 out WIDTH_A_80 each: A row i, columns 0..3.
- B00_80..B03_80 out WIDTH_B_80 each: B column j, rows 0..3.
- op_valid_80 out 1: operands valid this cycle.
- res_valid_80 out 1: downstream AB00_80 is valid this cycle.
- res_row_80 out 2: row tag for the result.
- res_col_80 out 2: column tag for the result.
- done_80 out 1: one-cycle completion pulse.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0.
  - All 32 storage entries cleared to 0.
  - Valid/tag delay line cleared.
- Reset mid-operation: identical to the above. Any in-flight sequence is abandoned with no done_80.
- Storage:
  - Write occurs at the clock edge when wr_en_80=1 and state is IDLE.
  - Writes in RUN or DRAIN are ignored.
  - Data is stored verbatim; illegal-value correction (e.g. A = 0x100) is downstream's job.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - busy_80=0, op_valid_80=0, operand outputs 0.
  - start_80=1 with wr_en_80=0 -> RUN, counters i=j=0.
  - start_80=1 and wr_en_80=1 in the same cycle -> the write happens and start is ignored.
- RUN:
  - Lasts exactly 16 cycles, starting the cycle after start was sampled.
  - Each cycle: op_valid_80=1, A0k_80=A[i][k], B0k_80=B[k][j] for k=0..3.
  - Order is row-major with j fastest: (0,0),(0,1),...,(0,3),(1,0),...,(3,3).
  - Operand outputs are registered, with no combinational path from inputs.
  - After the (3,3) cycle -> DRAIN.
- DRAIN:
  - Lasts PIPE_LAT cycles; op_valid_80=0 and operand outputs 0.
  - Then -> IDLE.
- busy_80: 1 in RUN and DRAIN. start_80 while busy is ignored.
- Result tagging:
  - res_valid_80, res_row_80 and res_col_80 equal op_valid_80, i and j delayed exactly PIPE_LAT cycles.
  - Tags are 0 whenever res_valid_80=0.
- done_80:
  - Single-cycle pulse in the first IDLE cycle after DRAIN.
  - This is one cycle after the (3,3) result's res_valid_80.
  - busy_80=0 in that cycle, and a new start is accepted in that cycle.
- Counters: wrap 3->0 on j, increment i. No other wrap behaviour.
- Total latency from start sampled to done_80 = 16 + PIPE_LAT + 1 cycles.

Test Plan:
1. Assert rst_80 2 cycles -> all outputs 0, busy_80=0. Start with no writes -> 16 op_valid_80 cycles, all operands 0.
2. Load A[r][c]=r*4+c+1 and B[r][c]=0x10*r+c, then start -> at 7th op_valid_80 cycle (i=1,j=2): A00..A03=5,6,7,8 and B00..B03=0x02,0x12,0x22,0x32. Last cycle: A=13..16, B=0x03,0x13,0x23,0x33.
3. PIPE_LAT=1, sequence from test 2:
   - First res_valid_80 one cycle after first op_valid_80, with tag (0,0).
   - 16 consecutive res_valid_80 cycles, last tag (3,3).
   - done_80 high the next cycle only; busy_80 falls that cycle.
4. During RUN, write A[0]=0x0FF and pulse start_80 -> sequence unaffected, no restart. A later sequence still shows A00_80=1 for row 0.
5. Assert rst_80 during 5th op_valid_80 cycle -> next cycle all outputs 0, no done_80. A new start produces all-zero operands (storage cleared).
6. wr_en_80=1, wr_sel_80=0, wr_addr_80=0, wr_data_80=0x100 in the same cycle as start_80 -> stays IDLE. Next start presents A00_80=0x100 at (0,0).
